ov_7670_display: RTL

Frame-buffer scan-out engine: reads the 24-bit pixels that the OV7670 capture path writes into the 640x480 frame buffer and drives a VGA raster (RGB888 plus syncs). It is the read-side counterpart of the capture writer, sharing the same 19-bit linear pixel address map (addr = y*640 + x). It runs in the CLOCK_50 domain and uses an internal divide-by-2 pixel tick (25 MHz).

---
 rtl/ov_7670_display.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ov_7670_display.sv
// ov_7670_display: VGA scan-out engine for the OV7670 640x480 frame buffer.
// Reads 24-bit {R,G,B} pixels at linear address y*H_ACTIVE + x and drives
// RGB888 plus active-low syncs on a divide-by-2 pixel tick.
// Optional feature macro: DISPLAY_TESTPAT_EN (8 vertical colour bars on test_pat).
module ov_7670_display #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [23:0]       rd_data,
    input  logic              test_pat,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0]    H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    H_SS   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    H_SE   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]    V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    V_SS   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    V_SE   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic              tick_q;
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
    logic              active, hs_raw, vs_raw, origin;
    logic              act_s1_q, hs_s1_q, vs_s1_q;
    logic [23:0]       rgb_d;

`ifdef DISPLAY_TESTPAT_EN
    localparam logic [H_W-1:0] BAR_C = H_W'(H_ACTIVE / 8);
    logic       pat_s1_q;
    logic [2:0] bar_s1_q;
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;
`else
    logic unused_test_pat;
    assign unused_test_pat = test_pat;
`endif

    // Stage 0: raster decode, read strobe/address and next counter values
    always_comb begin
        active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_raw   = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
        vs_raw   = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
        origin   = (h_cnt_q == '0) && (v_cnt_q == '0);
        addr_cur = origin ? '0 : addr_q;
`ifdef DISPLAY_TESTPAT_EN
        rd_en    = tick_q && active && !test_pat;
        bar_idx  = 3'(h_cnt_q / BAR_C);
`else
        rd_en    = tick_q && active;
`endif
        rd_addr     = addr_cur;
        frame_start = tick_q && origin;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        addr_d   = addr_q;
        if (tick_q) begin
            h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
            if (h_cnt_q == H_LAST)
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            // address advances on every active pixel, even while the test
            // pattern suppresses reads, so the map stays frame-locked
            if (active)
                addr_d = (addr_cur == A_LAST) ? '0 : addr_cur + 1'b1;
        end
    end

    // Pixel tick, raster counters and the one-pixel delay of stage-0 flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q   <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            addr_q   <= '0;
            act_s1_q <= 1'b0;
            hs_s1_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
`ifdef DISPLAY_TESTPAT_EN
            pat_s1_q <= 1'b0;
            bar_s1_q <= '0;
`endif
        end else begin
            tick_q  <= !tick_q;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
            if (tick_q) begin
                act_s1_q <= active;
                hs_s1_q  <= hs_raw;
                vs_s1_q  <= vs_raw;
`ifdef DISPLAY_TESTPAT_EN
                pat_s1_q <= test_pat;
                bar_s1_q <= bar_idx;
`endif
            end
        end
    end

    // Stage 1 colour select: RAM data, colour bar or black outside the active area
    always_comb begin
        rgb_d = '0;
`ifdef DISPLAY_TESTPAT_EN
        case (bar_s1_q)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        if (act_s1_q)
            rgb_d = pat_s1_q ? {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}} : rd_data;
`else
        if (act_s1_q)
            rgb_d = rd_data;
`endif
    end

    // Output registers load on the non-tick cycle, when the RAM data of the
    // previous tick is valid, so every output is one pixel behind the counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (!tick_q) begin
            {vga_r, vga_g, vga_b} <= rgb_d;
            vga_hs      <= hs_s1_q;
            vga_vs      <= vs_s1_q;
            vga_blank_n <= act_s1_q;
        end
    end

endmodule
